// File: rtl/receiver.sv
// Receiver stage: buffers incoming packets with their forward/drop verdicts,
// forwards accepted packets with the module ID stamped into metadata word 0,
// silently drains rejected packets, and passes the control channel straight
// through.
module receiver #(
  parameter logic [7:0] LMID  = 8'd1,
  parameter int         w_pkt = 134
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pktin_data_wr,
  input  logic [w_pkt-1:0] pktin_data,
  input  logic             pktin_data_valid_wr,
  input  logic             pktin_data_valid,
  output logic             pktin_ready,
  output logic             pktout_data_wr,
  output logic [w_pkt-1:0] pktout_data,
  input  logic             pktout_ready,
  input  logic             cin_data_wr,
  input  logic [w_pkt-1:0] cin_data,
  output logic             cin_ready,
  output logic             cout_data_wr,
  output logic [w_pkt-1:0] cout_data,
  input  logic             cout_ready,
  output logic [31:0]      pkt_fwd_cnt,
  output logic [31:0]      pkt_drop_cnt,
  output logic             err_overflow
);

  typedef enum logic [1:0] {IDLE, META, SEND, DISCARD} state_t;

  // Data FIFO storage and bookkeeping
  logic [w_pkt-1:0] dmem_q [256];
  logic [7:0]       dwptr_q, drptr_q;
  logic [8:0]       dcnt_q, dcnt_d;
  logic [w_pkt-1:0] dout_q;

  // Verdict FIFO storage and bookkeeping
  logic [63:0]      vmem_q;
  logic [5:0]       vwptr_q, vrptr_q;
  logic [6:0]       vcnt_q, vcnt_d;

  logic             dpush, dpop, vpush, vpop;
  logic             rd_en, start, dout_tail;

  state_t           state_q;
  logic             verdict_q;
  logic             pktin_ready_q;
  logic             pktout_wr_q;
  logic [w_pkt-1:0] pktout_data_q;
  logic [31:0]      fwd_cnt_q, drop_cnt_q;
  logic             err_q;

  assign cout_data_wr = cin_data_wr;
  assign cout_data    = cin_data;
  assign cin_ready    = cout_ready;

  assign pktin_ready    = pktin_ready_q;
  assign pktout_data_wr = pktout_wr_q;
  assign pktout_data    = pktout_data_q;
  assign pkt_fwd_cnt    = fwd_cnt_q;
  assign pkt_drop_cnt   = drop_cnt_q;
  assign err_overflow   = err_q;

  assign dout_tail = (dout_q[w_pkt-1 -: 2] == 2'b10);
  assign start     = (state_q == IDLE) && (vcnt_q != 7'd0) && pktout_ready;

  assign dpush = pktin_data_wr && (dcnt_q != 9'd256);
  assign dpop  = rd_en && (dcnt_q != 9'd0);
  assign vpush = pktin_data_valid_wr && (vcnt_q != 7'd64);
  assign vpop  = start;

  assign dcnt_d = dcnt_q + {8'd0, dpush} - {8'd0, dpop};
  assign vcnt_d = vcnt_q + {6'd0, vpush} - {6'd0, vpop};

  // Keep reading one word ahead while a packet is in flight; stop once the tail is in the output register
  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      IDLE:    rd_en = start;
      META:    rd_en = !dout_tail;
      SEND:    rd_en = !dout_tail;
      DISCARD: rd_en = !dout_tail;
      default: rd_en = 1'b0;
    endcase
  end

  // FIFO storage arrays; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (dpush) dmem_q[dwptr_q] <= pktin_data;
    if (vpush) vmem_q[vwptr_q] <= pktin_data_valid;
  end

  // FIFO pointers, occupancy, registered read data, backpressure and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwptr_q       <= 8'd0;
      drptr_q       <= 8'd0;
      dcnt_q        <= 9'd0;
      dout_q        <= '0;
      vwptr_q       <= 6'd0;
      vrptr_q       <= 6'd0;
      vcnt_q        <= 7'd0;
      pktin_ready_q <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      if (dpush) dwptr_q <= dwptr_q + 8'd1;
      if (dpop) begin
        drptr_q <= drptr_q + 8'd1;
        dout_q  <= dmem_q[drptr_q];
      end
      if (vpush) vwptr_q <= vwptr_q + 6'd1;
      if (vpop)  vrptr_q <= vrptr_q + 6'd1;
      dcnt_q        <= dcnt_d;
      vcnt_q        <= vcnt_d;
      pktin_ready_q <= (dcnt_d < 9'd200) && (vcnt_d < 7'd60);
      if ((pktin_data_wr && !dpush) || (pktin_data_valid_wr && !vpush)) err_q <= 1'b1;
    end
  end

  // Packet sequencer: waits for a verdict, then forwards or drains exactly one packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      verdict_q     <= 1'b0;
      pktout_wr_q   <= 1'b0;
      pktout_data_q <= '0;
      fwd_cnt_q     <= 32'd0;
      drop_cnt_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          pktout_wr_q <= 1'b0;
          if (start) begin
            verdict_q <= vmem_q[vrptr_q];
            state_q   <= META;
          end
        end
        META: begin
          if (verdict_q) begin
            pktout_wr_q   <= 1'b1;
            pktout_data_q <= {dout_q[w_pkt-1:96], LMID, dout_q[87:0]};
            if (dout_tail) begin
              fwd_cnt_q <= fwd_cnt_q + 32'd1;
              state_q   <= IDLE;
            end else begin
              state_q <= SEND;
            end
          end else begin
            pktout_wr_q <= 1'b0;
            if (dout_tail) begin
              drop_cnt_q <= drop_cnt_q + 32'd1;
              state_q    <= IDLE;
            end else begin
              state_q <= DISCARD;
            end
          end
        end
        SEND: begin
          pktout_wr_q   <= 1'b1;
          pktout_data_q <= dout_q;
          if (dout_tail) begin
            fwd_cnt_q <= fwd_cnt_q + 32'd1;
            state_q   <= IDLE;
          end
        end
        DISCARD: begin
          pktout_wr_q <= 1'b0;
          if (dout_tail) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
            state_q    <= IDLE;
          end
        end
        default: begin
          pktout_wr_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for the receiver: packets and verdicts go in, the bench
// predicts the forwarded word stream and the counters from the packet rules.
module tb_receiver;

  localparam int W = 134;

  logic          clk = 1'b0;
  logic          reset;
  logic          pktin_data_wr;
  logic [W-1:0]  pktin_data;
  logic          pktin_data_valid_wr;
  logic          pktin_data_valid;
  logic          pktin_ready;
  logic          pktout_data_wr;
  logic [W-1:0]  pktout_data;
  logic          pktout_ready;
  logic          cin_data_wr;
  logic [W-1:0]  cin_data;
  logic          cin_ready;
  logic          cout_data_wr;
  logic [W-1:0]  cout_data;
  logic          cout_ready;
  logic [31:0]   pkt_fwd_cnt;
  logic [31:0]   pkt_drop_cnt;
  logic          err_overflow;

  int            nChecks = 0;
  int            nFails = 0;
  logic [W-1:0]  expQ[$];
  logic [W-1:0]  seen[$];
  logic [W-1:0]  pktBuf[$];
  logic [31:0]   modelFwd = 32'd0;
  logic [31:0]   modelDrop = 32'd0;
  int            strobeCount = 0;
  bit            errCheckOn = 1'b1;
  bit            randReady = 1'b0;
  bit            fixedReady = 1'b1;

  receiver dut (
    .clk                 (clk),
    .reset               (reset),
    .pktin_data_wr       (pktin_data_wr),
    .pktin_data          (pktin_data),
    .pktin_data_valid_wr (pktin_data_valid_wr),
    .pktin_data_valid    (pktin_data_valid),
    .pktin_ready         (pktin_ready),
    .pktout_data_wr      (pktout_data_wr),
    .pktout_data         (pktout_data),
    .pktout_ready        (pktout_ready),
    .cin_data_wr         (cin_data_wr),
    .cin_data            (cin_data),
    .cin_ready           (cin_ready),
    .cout_data_wr        (cout_data_wr),
    .cout_data           (cout_data),
    .cout_ready          (cout_ready),
    .pkt_fwd_cnt         (pkt_fwd_cnt),
    .pkt_drop_cnt        (pkt_drop_cnt),
    .err_overflow        (err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] randWord();
    return {6'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Build a packet of n random words with correct head/body/tail markers
  task automatic makePacket(input int n);
    logic [W-1:0] w;
    pktBuf.delete();
    for (int i = 0; i < n; i++) begin
      w = randWord();
      w[W-1 -: 2] = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
      pktBuf.push_back(w);
    end
  endtask

  // Verdict strobe plus reference model update: forwarded packets get LMID in word 0
  task automatic issueVerdict(input bit v);
    logic [W-1:0] w;
    pktin_data_valid_wr = 1'b1;
    pktin_data_valid    = v;
    if (v) begin
      for (int i = 0; i < pktBuf.size(); i++) begin
        w = pktBuf[i];
        if (i == 0) w[95:88] = 8'h01;
        expQ.push_back(w);
      end
      modelFwd = modelFwd + 32'd1;
    end else begin
      modelDrop = modelDrop + 32'd1;
    end
  endtask

  // Send pktBuf, verdict with the tail (vDelay 0) or vDelay cycles after it
  task automatic applyStimulus(input bit v, input int vDelay);
    int c = 0;
    while (!pktin_ready && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (!pktin_ready) failNow("pktin_ready_wait");
    for (int i = 0; i < pktBuf.size(); i++) begin
      pktin_data_wr = 1'b1;
      pktin_data    = pktBuf[i];
      if (i == pktBuf.size() - 1 && vDelay == 0) issueVerdict(v);
      @(negedge clk);
      pktin_data_valid_wr = 1'b0;
    end
    pktin_data_wr = 1'b0;
    if (vDelay > 0) begin
      repeat (vDelay - 1) @(negedge clk);
      issueVerdict(v);
      @(negedge clk);
      pktin_data_valid_wr = 1'b0;
    end
  endtask

  task automatic drain();
    int c = 0;
    randReady  = 1'b0;
    fixedReady = 1'b1;
    while (expQ.size() != 0 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    if (expQ.size() != 0) failNow("drain");
    repeat (200) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    expQ.delete();
    modelFwd  = 32'd0;
    modelDrop = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_fwd"},  W'(pkt_fwd_cnt),  W'(modelFwd));
    checkOutput({tag, "_drop"}, W'(pkt_drop_cnt), W'(modelDrop));
  endtask

  // Background drivers for downstream readiness and the control channel
  initial begin
    pktout_ready = 1'b1;
    cin_data_wr  = 1'b0;
    cin_data     = '0;
    cout_ready   = 1'b0;
    forever begin
      @(negedge clk);
      pktout_ready = randReady ? 1'($urandom()) : fixedReady;
      cin_data_wr  = 1'($urandom());
      cin_data     = randWord();
      cout_ready   = 1'($urandom());
    end
  end

  // Compare process: every forwarded word against the model, no bubbles inside a packet
  initial begin : cmp
    bit           midPkt;
    logic [W-1:0] e;
    midPkt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      checkOutput("cout_data_wr", W'(cout_data_wr), W'(cin_data_wr));
      checkOutput("cout_data", cout_data, cin_data);
      checkOutput("cin_ready", W'(cin_ready), W'(cout_ready));
      if (reset) begin
        midPkt = 1'b0;
      end else begin
        if (errCheckOn) checkOutput("err_overflow_idle", W'(err_overflow), W'(0));
        if (midPkt) checkOutput("no_bubble", W'(pktout_data_wr), W'(1));
        if (pktout_data_wr) begin
          strobeCount++;
          seen.push_back(pktout_data);
          if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected_strobe: got %0h, expected no strobe", pktout_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("pktout_data", pktout_data, e);
          end
          midPkt = (pktout_data[W-1 -: 2] != 2'b10);
        end else begin
          midPkt = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    reset               = 1'b1;
    pktin_data_wr       = 1'b0;
    pktin_data          = '0;
    pktin_data_valid_wr = 1'b0;
    pktin_data_valid    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pktout_wr", W'(pktout_data_wr), W'(0));
    checkOutput("rst_pktin_ready", W'(pktin_ready), W'(1));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_pktout_data", pktout_data, '0);
    checkOutput("rst_fwd", W'(pkt_fwd_cnt), W'(0));
    checkOutput("rst_drop", W'(pkt_drop_cnt), W'(0));
    checkOutput("rst_err", W'(err_overflow), W'(0));

    $display("[TB] 4-word forwarded packet");
    seen.delete();
    makePacket(4);
    pktBuf[0] = {2'b01, 36'h0, 8'hAB, 88'h5};
    applyStimulus(1'b1, 0);
    drain();
    checkOutput("fwd4_len", W'(seen.size()), W'(4));
    checkOutput("fwd4_word0", seen[0], {2'b01, 36'h0, 8'h01, 88'h5});
    checkOutput("fwd4_word3", seen[3], pktBuf[3]);
    checkOutput("fwd4_cnt", W'(pkt_fwd_cnt), W'(1));

    $display("[TB] dropped packet then forwarded packet");
    s0 = strobeCount;
    makePacket(3);
    applyStimulus(1'b0, 1);
    drain();
    checkOutput("drop_no_strobe", W'(strobeCount), W'(s0));
    checkOutput("drop_cnt", W'(pkt_drop_cnt), W'(1));
    makePacket(5);
    applyStimulus(1'b1, 0);
    drain();
    checkOutput("after_drop_strobes", W'(strobeCount - s0), W'(5));
    checkCounters("after_drop");

    $display("[TB] downstream stalled with two packets queued");
    fixedReady = 1'b0;
    s0 = strobeCount;
    makePacket(3);
    applyStimulus(1'b1, 0);
    makePacket(6);
    applyStimulus(1'b1, 2);
    repeat (30) @(negedge clk);
    checkOutput("stall_no_strobe", W'(strobeCount), W'(s0));
    drain();
    checkOutput("stall_strobes", W'(strobeCount - s0), W'(9));
    checkOutput("stall_fwd", W'(pkt_fwd_cnt), W'(4));

    $display("[TB] randomized traffic");
    randReady = 1'b1;
    for (int k = 0; k < 40; k++) begin
      makePacket(2 + int'($urandom_range(6, 0)));
      applyStimulus(1'($urandom()), int'($urandom_range(3, 0)));
      randReady = 1'b1;
    end
    drain();
    checkCounters("random");

    $display("[TB] forwarded counter wrap");
    @(negedge clk);
    force dut.fwd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fwd_cnt_q;
    modelFwd = 32'hFFFF_FFFF;
    checkOutput("wrap_preload", W'(pkt_fwd_cnt), W'(32'hFFFF_FFFF));
    @(negedge clk);
    makePacket(3);
    applyStimulus(1'b1, 0);
    drain();
    checkOutput("wrap_zero", W'(pkt_fwd_cnt), W'(0));
    checkCounters("wrap");

    $display("[TB] reset during a forwarded packet");
    makePacket(5);
    applyStimulus(1'b1, 0);
    s0 = strobeCount;
    begin
      int c = 0;
      while (strobeCount < s0 + 2 && c < 100) begin
        @(negedge clk);
        c++;
      end
      if (strobeCount < s0 + 2) failNow("midpkt_wait");
    end
    reset = 1'b1;
    expQ.delete();
    modelFwd  = 32'd0;
    modelDrop = 32'd0;
    #1;
    checkOutput("midrst_wr", W'(pktout_data_wr), W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", W'(pktin_ready), W'(1));
    checkOutput("midrst_data", pktout_data, '0);
    checkCounters("midrst");
    s0 = strobeCount;
    repeat (20) @(negedge clk);
    checkOutput("midrst_empty", W'(strobeCount), W'(s0));
    makePacket(4);
    applyStimulus(1'b1, 0);
    drain();
    checkCounters("post_rst");

    $display("[TB] data FIFO fill and overflow");
    errCheckOn = 1'b0;
    fixedReady = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 200; i++) begin
      pktin_data_wr = 1'b1;
      pktin_data    = randWord();
      @(negedge clk);
      if (i == 199) checkOutput("fill199_ready", W'(pktin_ready), W'(1));
      if (i == 200) checkOutput("fill200_ready", W'(pktin_ready), W'(0));
    end
    for (int j = 1; j <= 57; j++) begin
      pktin_data_wr = 1'b1;
      pktin_data    = randWord();
      @(negedge clk);
      if (j == 56) checkOutput("full_no_err", W'(err_overflow), W'(0));
      if (j == 57) checkOutput("overflow_err", W'(err_overflow), W'(1));
    end
    pktin_data_wr = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("overflow_sticky", W'(err_overflow), W'(1));
    doReset();
    checkOutput("overflow_cleared", W'(err_overflow), W'(0));
    checkOutput("overflow_ready", W'(pktin_ready), W'(1));
    errCheckOn = 1'b1;
    fixedReady = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter LMID, default 8'd1, module ID written into forwarded metadata word 0 bits [95:88].
REQ-002 Parameter w_pkt, default 134, FAST2.0 packet word width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pktin_data_wr  input  1  write strobe for pktin_data.
REQ-006 pktin_data  input  134  packet word; [133:132] 01=head, 11=body, 10=tail.
REQ-007 pktin_data_valid_wr  input  1  one-cycle verdict strobe, asserted on or after the tail-word cycle.
REQ-008 pktin_data_valid  input  1  verdict: 1 forward, 0 drop.
REQ-009 pktin_ready  output  1  registered; upstream may start a new packet only while high.
REQ-010 pktout_data_wr  output  1  output word strobe.
REQ-011 pktout_data  output  134  output packet word.
REQ-012 pktout_ready  input  1  downstream can accept one whole packet.
REQ-013 cin_data_wr / cin_data / cin_ready  in/in/out  1/134/1  control channel in.
REQ-014 cout_data_wr / cout_data / cout_ready  out/out/in  1/134/1  control channel out.
REQ-015 pkt_fwd_cnt  output  32  forwarded-packet count.
REQ-016 pkt_drop_cnt  output  32  dropped-packet count.
REQ-017 err_overflow  output  1  sticky overflow flag.

Function
REQ-018 Control channel combinational: cout_data_wr=cin_data_wr, cout_data=cin_data, cin_ready=cout_ready.
REQ-019 Data FIFO: 256x134, first-word-fall-through not used (dout valid the cycle after rd_en); every pktin_data_wr word written.
REQ-020 Verdict FIFO: 64x1; each pktin_data_valid_wr pushes pktin_data_valid.
REQ-021 pktin_ready registered each cycle: 1 iff data count < 200 and verdict count < 60.
REQ-022 Write to a full FIFO: word/verdict discarded, err_overflow set to 1 until reset.
REQ-023 States: IDLE, META, SEND, DISCARD.
REQ-024 IDLE: if verdict FIFO non-empty and pktout_ready=1: pop verdict, assert data rd_en, go META; else hold, pktout_data_wr=0.
REQ-025 META: if verdict=1, output first word with [95:88] replaced by LMID[7:0], all other bits unchanged, pktout_data_wr=1, go SEND; if verdict=0, pktout_data_wr=0, go DISCARD.
REQ-026 SEND: output each FIFO word unmodified, pktout_data_wr=1, one per cycle, no bubbles; on tail word deassert rd_en, increment pkt_fwd_cnt, go IDLE.
REQ-027 DISCARD: read words at one per cycle with pktout_data_wr=0; on tail deassert rd_en, increment pkt_drop_cnt, go IDLE.
REQ-028 pktout_ready sampled only in IDLE; a started packet completes regardless of later pktout_ready.
REQ-029 Latency: first forwarded word on pktout no later than 3 cycles after IDLE start condition; next packet may start the cycle after returning to IDLE.
REQ-030 Counters wrap 0xFFFFFFFF -> 0.
REQ-031 Verdict and tail word written in the same cycle are legal; a packet is never read before its verdict is stored.

Reset
REQ-032 On reset: both FIFOs flushed, state IDLE, pktout_data_wr=0, pktout_data=0, pktin_ready=1, counters=0, err_overflow=0.
REQ-033 Reset mid-packet aborts the packet with no further pktout_data_wr and no counter update.

Verification
REQ-034 4-word packet, verdict=1, pktout_ready=1 -> 4 consecutive strobes, word0[95:88]=0x01, other bits identical, pkt_fwd_cnt=1.
REQ-035 3-word packet, verdict=0 -> no pktout_data_wr, pkt_drop_cnt=1, next forwarded packet intact.
REQ-036 pktout_ready=0 with 2 packets queued -> no output; raise ready -> both forwarded back-to-back in order.
REQ-037 Fill data FIFO to 200 words -> pktin_ready=0 next cycle; write 57 more -> err_overflow=1.
REQ-038 Assert reset during SEND of word 2 of 5 -> pktout_data_wr=0, pktin_ready=1, counters 0, FIFOs empty.
REQ-039 Preload pkt_fwd_cnt to 0xFFFFFFFF (force), forward one packet -> counter reads 0.
